// File: rtl/datapath_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_control_sequencer
//  Description : Moore fetch/decode/execute sequencer driving the Datapath
//                control strobes for register-format instructions.
//  Revision    : 1.0
// ============================================================================
module datapath_control_sequencer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic             mem_ready,
  input  logic [31:0]      ir,
  output logic             pc_out,
  output logic             pc_increment,
  output logic             mar_in,
  output logic             pc_in,
  output logic             read,
  output logic             mdr_in,
  output logic             mdr_out,
  output logic             ir_in,
  output logic             y_in,
  output logic             zhigh_in,
  output logic             zlow_in,
  output logic             zhigh_out,
  output logic             zlow_out,
  output logic             hi_in,
  output logic             lo_in,
  output logic [15:0]      r_in,
  output logic [15:0]      r_out,
  output logic [4:0]       op_code,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd8,
    S_ERR  = 4'd9
  } state_t;

  localparam logic [4:0]  OP_ALU_FIRST = 5'b00011;
  localparam logic [4:0]  OP_ALU_LAST  = 5'b01011;
  localparam logic [4:0]  OP_MUL       = 5'b01111;
  localparam logic [4:0]  OP_DIV       = 5'b10000;
  localparam logic [4:0]  OP_NEG       = 5'b10001;
  localparam logic [4:0]  OP_NOT       = 5'b10010;
  localparam logic [4:0]  OP_NOP       = 5'b11010;
  localparam logic [4:0]  OP_HALT      = 5'b11011;
  localparam logic [15:0] C_WAIT_LAST  = 16'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [15:0]      wait_q, wait_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [4:0] w_op;
  logic [3:0] w_ra, w_rb, w_rc;
  logic       w_alu3, w_muldiv, w_negnot, w_nop, w_halt;
  logic       w_retire;
  logic       unused_ir_low;

  assign w_op          = ir[31:27];
  assign w_ra          = ir[26:23];
  assign w_rb          = ir[22:19];
  assign w_rc          = ir[18:15];
  assign unused_ir_low = ^ir[14:0];

  assign w_alu3   = (w_op >= OP_ALU_FIRST) && (w_op <= OP_ALU_LAST);
  assign w_muldiv = (w_op == OP_MUL) || (w_op == OP_DIV);
  assign w_negnot = (w_op == OP_NEG) || (w_op == OP_NOT);
  assign w_nop    = (w_op == OP_NOP);
  assign w_halt   = (w_op == OP_HALT);

  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    onehot16 = 16'h0001 << idx;
  endfunction

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  // The wait counter is only meaningful inside T1; it is cleared everywhere else
  // so that every fresh T1 starts at zero (which also marks the pc_in cycle).
  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    retired_d = retired_q;
    w_retire  = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1: begin
        if (mem_ready)                state_d = S_T2;
        else if (wait_q == C_WAIT_LAST) state_d = S_ERR;
        else                          wait_d  = wait_q + 16'd1;
      end
      S_T2:   state_d = S_T3;
      S_T3: begin
        if (w_alu3 || w_muldiv || w_negnot) state_d = S_T4;
        else if (w_nop)                    w_retire = 1'b1;
        else if (w_halt)                   state_d = S_HALT;
        else                               state_d = S_ERR;
      end
      S_T4:   state_d = S_T5;
      S_T5: begin
        if (w_muldiv) state_d  = S_T6;
        else          w_retire = 1'b1;
      end
      S_T6:   w_retire = 1'b1;
      S_HALT: state_d = S_HALT;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
    if (w_retire) begin
      retired_d = retired_q + CNT_W'(1);
      state_d   = run ? S_T0 : S_IDLE;
    end
  end

  always_comb begin
    pc_out       = 1'b0;
    pc_increment = 1'b0;
    mar_in       = 1'b0;
    pc_in        = 1'b0;
    read         = 1'b0;
    mdr_in       = 1'b0;
    mdr_out      = 1'b0;
    ir_in        = 1'b0;
    y_in         = 1'b0;
    zhigh_in     = 1'b0;
    zlow_in      = 1'b0;
    zhigh_out    = 1'b0;
    zlow_out     = 1'b0;
    hi_in        = 1'b0;
    lo_in        = 1'b0;
    r_in         = 16'h0000;
    r_out        = 16'h0000;
    op_code      = 5'b00000;
    case (state_q)
      S_T0: begin
        pc_out       = 1'b1;
        pc_increment = 1'b1;
        mar_in       = 1'b1;
        zlow_in      = 1'b1;
        zhigh_in     = 1'b1;
      end
      S_T1: begin
        zlow_out = 1'b1;
        read     = 1'b1;
        mdr_in   = 1'b1;
        pc_in    = (wait_q == 16'd0);
      end
      S_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      S_T3: begin
        if (w_alu3) begin
          r_out = onehot16(w_rb);
          y_in  = 1'b1;
        end else if (w_muldiv) begin
          r_out = onehot16(w_ra);
          y_in  = 1'b1;
        end
      end
      S_T4: begin
        r_out    = w_alu3 ? onehot16(w_rc) : onehot16(w_rb);
        zlow_in  = 1'b1;
        zhigh_in = 1'b1;
        op_code  = w_op;
      end
      S_T5: begin
        zlow_out = 1'b1;
        if (w_muldiv) lo_in = 1'b1;
        else          r_in  = onehot16(w_ra);
      end
      S_T6: begin
        zhigh_out = 1'b1;
        hi_in     = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy    = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_ERR);
  assign halted  = (state_q == S_HALT);
  assign err     = (state_q == S_ERR);
  assign retired = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_datapath_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_datapath_control_sequencer
//  Description : Randomised self-checking bench; per-cycle expected strobe
//                traces are built from the instruction-class step tables.
//  Revision    : 1.0
// ============================================================================
module tb_datapath_control_sequencer;

  localparam int TIMEOUT = 5;
  localparam int CW      = 4;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          run = 1'b0;
  logic          mem_ready = 1'b0;
  logic [31:0]   ir = 32'h0;
  logic          pc_out, pc_increment, mar_in, pc_in, read, mdr_in, mdr_out, ir_in, y_in;
  logic          zhigh_in, zlow_in, zhigh_out, zlow_out, hi_in, lo_in;
  logic [15:0]   r_in, r_out;
  logic [4:0]    op_code;
  logic          busy, halted, err;
  logic [CW-1:0] retired;

  datapath_control_sequencer #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
    .clk(clk), .clr(clr), .run(run), .mem_ready(mem_ready), .ir(ir),
    .pc_out(pc_out), .pc_increment(pc_increment), .mar_in(mar_in), .pc_in(pc_in),
    .read(read), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in),
    .zhigh_in(zhigh_in), .zlow_in(zlow_in), .zhigh_out(zhigh_out), .zlow_out(zlow_out),
    .hi_in(hi_in), .lo_in(lo_in), .r_in(r_in), .r_out(r_out), .op_code(op_code),
    .busy(busy), .halted(halted), .err(err), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pc_out, pc_increment, mar_in, pc_in, read, mdr_in, mdr_out, ir_in, y_in;
    logic zhigh_in, zlow_in, zhigh_out, zlow_out, hi_in, lo_in;
    logic [15:0] r_in, r_out;
    logic [4:0]  op_code;
    logic busy, halted, err;
    logic [CW-1:0] retired;
  } outs_t;

  outs_t obs;
  assign obs = {pc_out, pc_increment, mar_in, pc_in, read, mdr_in, mdr_out, ir_in, y_in,
                zhigh_in, zlow_in, zhigh_out, zlow_out, hi_in, lo_in,
                r_in, r_out, op_code, busy, halted, err, retired};

  int    checks = 0;
  int    errors = 0;
  int    inv_checks = 0;
  int    inv_errs = 0;
  bit    inv_en = 1'b0;
  int    exp_ret = 0;
  bit    dut_idle = 1'b0;
  outs_t exp_q[$];
  bit    mr_q[$];
  bit    rn_q[$];
  int    legal_ops[14] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 15, 16, 17, 18, 26};
  int    bad_ops[17]   = '{0, 1, 2, 12, 13, 14, 19, 20, 21, 22, 23, 24, 25, 28, 29, 30, 31};

  // Bus exclusivity and one-hot register strobes, every cycle out of reset.
  always @(negedge clk) begin
    if (inv_en && clr) begin
      inv_checks++;
      if (($countones({pc_out, zlow_out, zhigh_out, mdr_out}) + $countones(r_out)) > 1 ||
          $countones(r_in) > 1) begin
        inv_errs++;
        $display("FAIL bus_invariant t=%0t: drivers pc/zl/zh/mdr=%b r_out=%h r_in=%h required <=1 driver, one-hot",
                 $time, {pc_out, zlow_out, zhigh_out, mdr_out}, r_out, r_in);
      end
    end
  end

  function automatic outs_t busy_v();
    outs_t v;
    v = '0;
    v.busy = 1'b1;
    v.retired = CW'(exp_ret);
    return v;
  endfunction

  function automatic outs_t still_v();
    outs_t v;
    v = '0;
    v.retired = CW'(exp_ret);
    return v;
  endfunction

  function automatic logic [15:0] oh(input logic [3:0] n);
    logic [15:0] one;
    one = 16'h0001;
    return one << n;
  endfunction

  task automatic push_step(input outs_t e, input bit mr, input bit rn);
    exp_q.push_back(e);
    mr_q.push_back(mr);
    rn_q.push_back(rn);
  endtask

  // Drives one instruction from IDLE/T0 to retire (or to HALT/ERR) and compares
  // every cycle against the step table of its instruction class.
  task automatic exec_instr(input logic [31:0] instr, input int zeros, input bit run_after,
                            input string tag);
    outs_t e;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    bit alu3, muldiv, negnot, retires;
    op = instr[31:27]; ra = instr[26:23]; rb = instr[22:19]; rc = instr[18:15];
    alu3   = (op >= 5'd3 && op <= 5'd11);
    muldiv = (op == 5'd15 || op == 5'd16);
    negnot = (op == 5'd17 || op == 5'd18);
    retires = 1'b0;
    ir = instr;
    if (dut_idle) begin
      e = still_v();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s idle: got %h want %h", tag, obs, e);
      end
      run = 1'b1;
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    e = busy_v();
    e.pc_out = 1; e.pc_increment = 1; e.mar_in = 1; e.zlow_in = 1; e.zhigh_in = 1;
    push_step(e, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int k = 0; k <= zeros && k < TIMEOUT; k++) begin
      e = busy_v();
      e.zlow_out = 1; e.read = 1; e.mdr_in = 1; e.pc_in = (k == 0);
      push_step(e, (k == zeros), 1'($urandom_range(0, 1)));
    end
    if (zeros >= TIMEOUT) begin
      e = still_v(); e.err = 1;
      push_step(e, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end else begin
      e = busy_v(); e.mdr_out = 1; e.ir_in = 1;
      push_step(e, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (alu3 || muldiv || negnot) begin
        e = busy_v();
        if (alu3 || muldiv) begin
          e.r_out = oh(alu3 ? rb : ra);
          e.y_in = 1;
        end
        push_step(e, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        e = busy_v();
        e.r_out = oh(alu3 ? rc : rb); e.zlow_in = 1; e.zhigh_in = 1; e.op_code = op;
        push_step(e, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        e = busy_v(); e.zlow_out = 1;
        if (muldiv) begin
          e.lo_in = 1;
          push_step(e, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          e = busy_v(); e.zhigh_out = 1; e.hi_in = 1;
        end else begin
          e.r_in = oh(ra);
        end
        push_step(e, 1'($urandom_range(0, 1)), run_after);
        retires = 1'b1;
      end else if (op == 5'd26) begin
        push_step(busy_v(), 1'($urandom_range(0, 1)), run_after);
        retires = 1'b1;
      end else begin
        push_step(busy_v(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        e = still_v();
        if (op == 5'd27) e.halted = 1;
        else             e.err = 1;
        push_step(e, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end
    if (retires) exp_ret = (exp_ret + 1) % (1 << CW);
    foreach (exp_q[i]) begin
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL %s step%0d: got %h want %h", tag, i, obs, exp_q[i]);
      end
      mem_ready = mr_q[i];
      run = rn_q[i];
      @(negedge clk);
    end
    exp_q.delete(); mr_q.delete(); rn_q.delete();
    dut_idle = retires && !run_after;
  endtask

  // Asynchronous reset entered mid-cycle; released with run_rel applied.
  task automatic do_reset(input bit run_rel, input string tag);
    outs_t z;
    z = '0;
    #2 clr = 1'b0;
    #1;
    checks++;
    if (obs !== z) begin
      errors++;
      $display("FAIL %s async_reset: got %h want %h", tag, obs, z);
    end
    run = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== z) begin
      errors++;
      $display("FAIL %s reset_hold: got %h want %h", tag, obs, z);
    end
    run = run_rel;
    mem_ready = 1'b0;
    #2 clr = 1'b1;
    exp_ret = 0;
    @(negedge clk);
    dut_idle = !run_rel;
  endtask

  task automatic test_reset();
    @(negedge clk);
    do_reset(1'b0, "reset");
    inv_en = 1'b1;
  endtask

  task automatic test_shl();
    // shl R4,R3,R7: op=01011 Ra=4 Rb=3 Rc=7
    exec_instr(32'h5A1B_8000, 0, 1'b0, "shl");
  endtask

  task automatic test_mem_wait();
    exec_instr({5'd3, 4'd1, 4'd2, 4'd3, 15'd0}, 3, 1'b1, "wait3");
    exec_instr({5'd4, 4'd6, 4'd6, 4'd6, 15'd0}, TIMEOUT - 1, 1'b0, "wait_edge");
  endtask

  task automatic test_muldiv();
    exec_instr({5'b01111, 4'd2, 4'd5, 4'd0, 15'd0}, 0, 1'b0, "mul");
    exec_instr({5'b10000, 4'd15, 4'd0, 4'd9, 15'h1234}, 1, 1'b1, "div");
    exec_instr({5'b10001, 4'd7, 4'd7, 4'd1, 15'd0}, 0, 1'b1, "neg");
    exec_instr({5'b11010, 4'd3, 4'd3, 4'd3, 15'd0}, 2, 1'b0, "nop");
  endtask

  task automatic test_random();
    logic [31:0] instr;
    for (int n = 0; n < 40; n++) begin
      instr = {5'(legal_ops[$urandom_range(0, 13)]), 27'($urandom)};
      exec_instr(instr, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, TIMEOUT - 1)) : 0,
                 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_halt();
    outs_t e;
    exec_instr({5'b11011, 27'($urandom)}, 0, 1'b1, "halt");
    for (int i = 0; i < 6; i++) begin
      run = ~run;
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      e = still_v(); e.halted = 1;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL halt_sticky cyc%0d: got %h want %h", i, obs, e);
      end
    end
    do_reset(1'b0, "halt_exit");
  endtask

  task automatic test_illegal();
    outs_t e;
    exec_instr({5'b11111, 27'($urandom)}, 0, 1'b1, "op11111");
    do_reset(1'b1, "err_exit");
    exec_instr({5'(bad_ops[$urandom_range(0, 16)]), 27'($urandom)}, 0, 1'b1, "illegal");
    for (int i = 0; i < 3; i++) begin
      run = 1'($urandom_range(0, 1));
      @(negedge clk);
      e = still_v(); e.err = 1;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL err_sticky cyc%0d: got %h want %h", i, obs, e);
      end
    end
    do_reset(1'b0, "illegal_exit");
  endtask

  task automatic test_timeout();
    exec_instr({5'd5, 4'd1, 4'd2, 4'd3, 15'd0}, 1, 1'b1, "pre_timeout");
    exec_instr({5'd6, 4'd1, 4'd2, 4'd3, 15'd0}, TIMEOUT, 1'b1, "timeout");
    do_reset(1'b1, "timeout_exit");
  endtask

  task automatic test_reset_mid();
    ir = {5'b01111, 4'd2, 4'd5, 4'd0, 15'd0};
    run = 1'b1;
    mem_ready = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (op_code !== 5'b01111) begin
      errors++;
      $display("FAIL mid_t4_opcode: got %b want %b", op_code, 5'b01111);
    end
    do_reset(1'b1, "mid_t4");
    exec_instr({5'b01001, 4'd8, 4'd9, 4'd10, 15'd0}, 0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_shl();
    test_mem_wait();
    test_muldiv();
    test_random();
    test_halt();
    test_illegal();
    test_timeout();
    do_reset(1'b0, "pre_mid");
    test_reset_mid();
    checks++;
    if (inv_errs != 0) begin
      errors++;
      $display("FAIL bus_invariant_total: got %0d violations in %0d cycles want 0", inv_errs, inv_checks);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
